cdc_enable_sync_scheduler: RTL
==============================

Name: cdc_enable_sync_scheduler

Overview:
- Source-domain scheduler that shares one enable-based (mux) CDC synchronizer channel among NUM_REQ requesters.
- Arbitrates round-robin and drives the synchronizer's data and enable inputs.
- Holds the enable high for EN_CYCLES cycles and keeps the data stable for HOLD_CYCLES cycles, which satisfies the destination 2-FF enable-path latency.
- Sits entirely in the transmit clock domain, directly in front of the synchronizer's data/enable inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, payload width; equals the synchronizer data width.
- EN_CYCLES, 2, cycles o_sync_enable stays high per transfer (>=1).
- HOLD_CYCLES, 6, cycles o_sync_data stays stable after a transfer is accepted. Must be >= EN_CYCLES+1; otherwise elaboration fails.

Ports:
- i_clk, input, 1, transmit-domain clock; all logic is on its rising edge.
- i_rst, input, 1, synchronous, active-high reset.
- i_req_valid, input, NUM_REQ, per-requester valid.
- i_req_data, input, NUM_REQ*WIDTH, payload; requester k uses [k*WIDTH +: WIDTH].
- o_req_ready, output, NUM_REQ, one-hot accept strobe; transfer k happens when valid[k] & ready[k].
- o_sync_data, output, WIDTH, registered payload to the synchronizer data input.
- o_sync_enable, output, 1, registered enable to the synchronizer enable input.
- o_grant_id, output, clog2(NUM_REQ), index of the last accepted requester.
- o_busy, output, 1, high in ASSERT or HOLD.

Behaviour:
- Reset (clock edge with i_rst=1):
  - State goes to IDLE; o_sync_data=0, o_sync_enable=0, o_grant_id=0, o_busy=0, counter=0.
  - RR pointer is set so requester 0 has highest priority.
  - Reset overrides everything, including mid-ASSERT/HOLD; the enable drops on that same edge.
- States:
  - IDLE: o_busy=0. If any i_req_valid is set, the winner w is the first valid index searching upward, with wrap, from (last_grant+1) mod NUM_REQ (from 0 after reset).
    - o_req_ready[w]=1 combinationally in that cycle; all other ready bits are 0.
    - On the edge: o_sync_data <= data[w], o_grant_id <= w, pointer <= w, counter <= 0, state -> ASSERT.
    - If no valid is set, stay in IDLE with ready all 0.
  - ASSERT: o_sync_enable=1, counter increments. After EN_CYCLES cycles, go to HOLD with counter reset.
  - HOLD: o_sync_enable=0, data unchanged. After HOLD_CYCLES-EN_CYCLES cycles, go to IDLE.
- o_sync_enable is registered. It is 1 exactly in the EN_CYCLES cycles after the accept edge.
- o_sync_data changes only on an accept edge or on reset. It holds its last value through IDLE.
- o_req_ready is 0 in ASSERT/HOLD and while i_rst=1.
- Timing: accept at edge T gives enable high in cycles T+1..T+EN_CYCLES and data stable from T+1 through at least T+HOLD_CYCLES.
  - The next accept is possible at edge T+HOLD_CYCLES+1, so the minimum transfer period is HOLD_CYCLES+1 cycles.
- Requesters may drop valid in any cycle where they are not accepted, with no effect. Data sampled only at the accept edge.
- A single requester that is continuously valid is accepted every HOLD_CYCLES+1 cycles. Fairness: no requester waits more than NUM_REQ-1 transfers.
- Pointer wrap: after grant NUM_REQ-1, the search starts at 0.

Test Plan:
- Defaults, reset, then only valid[2]=1 with data[2]=0xA at cycle 3: ready[2]=1 in cycle 3; o_sync_data=0xA from cycle 4; enable=1 in cycles 4-5; busy=1 in cycles 4-9; IDLE in cycle 10.
- All four valid continuously with data 0x1,0x2,0x3,0x4: accept order is 0,1,2,3,0 with accepts 7 cycles apart; o_grant_id follows that order; each data value is stable 6 cycles.
- Grant to 3 last, then valid[0] and valid[3] both set: 0 is accepted first (wrap); 3 is accepted next.
- valid[1] held 2 cycles during HOLD, then dropped before IDLE: no accept; data and grant unchanged.
- i_rst=1 in the second ASSERT cycle: next edge gives enable=0, data=0, busy=0, IDLE. After release, requester 0 has priority over 1 when both are valid.
- EN_CYCLES=1, HOLD_CYCLES=2, single requester continuously valid: one-cycle enable pulse every 3 cycles; data changes only on accept edges.

Source files
------------

// File: rtl/cdc_enable_sync_scheduler_if.sv
// Requester and synchronizer-side signals of the enable-based CDC scheduler.
// The scheduler itself uses the slave view; requesters use the master view.
interface cdc_enable_sync_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       i_req_valid;
    logic [NUM_REQ*WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic [WIDTH-1:0]         o_sync_data;
    logic                     o_sync_enable;
    logic [IDW-1:0]           o_grant_id;
    logic                     o_busy;

    modport slave (
        input  i_req_valid, i_req_data,
        output o_req_ready, o_sync_data, o_sync_enable, o_grant_id, o_busy
    );

    modport master (
        output i_req_valid, i_req_data,
        input  o_req_ready, o_sync_data, o_sync_enable, o_grant_id, o_busy
    );
endinterface

// File: rtl/cdc_enable_sync_scheduler.sv
// Round-robin scheduler sharing one enable-based CDC synchronizer among NUM_REQ
// requesters; holds enable for EN_CYCLES and data for HOLD_CYCLES per transfer.
module cdc_enable_sync_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 4,
    parameter int EN_CYCLES   = 2,
    parameter int HOLD_CYCLES = 6
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    cdc_enable_sync_scheduler_if.slave    bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(HOLD_CYCLES + 1);

    generate
        if (EN_CYCLES < 1 || HOLD_CYCLES < EN_CYCLES + 1) begin : g_bad_params
            $error("cdc_enable_sync_scheduler: need EN_CYCLES >= 1 and HOLD_CYCLES >= EN_CYCLES+1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IDW-1:0]   start_q;
    logic [IDW-1:0]   grant_q;
    logic [WIDTH-1:0] data_q;
    logic             en_q;
    logic             busy_q;

    logic               found;
    logic [IDW-1:0]     win;
    logic [IDW-1:0]     win_nxt;
    logic [NUM_REQ-1:0] ready;

    // Upward search with wrap from start_q, the index after the last grant.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(start_q) + i) % NUM_REQ;
            if (!found && bus.i_req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign win_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + IDW'(1);

    always_comb begin
        ready = '0;
        if (state_q == IDLE && !i_rst && found) begin
            ready[win] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= '0;
            grant_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        data_q  <= bus.i_req_data[win*WIDTH +: WIDTH];
                        grant_q <= win;
                        start_q <= win_nxt;
                        cnt_q   <= '0;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (cnt_q == CW'(EN_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        en_q    <= 1'b0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    // Data stays put here so the destination sees it stable past the enable.
                    if (cnt_q == CW'(HOLD_CYCLES - EN_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ready   = ready;
    assign bus.o_sync_data   = data_q;
    assign bus.o_sync_enable = en_q;
    assign bus.o_grant_id    = grant_q;
    assign bus.o_busy        = busy_q;
endmodule
